store_data_aligner: RTL and testbench

//  Store-side counterpart of the load extract/extend path in the MEM/WB stage.

---
 rtl/store_data_aligner_pkg.sv | 20 ++
 rtl/store_data_aligner_lane_shifter.sv | 11 +
 rtl/store_data_aligner.sv | 83 ++++++++
 tb/tb_store_data_aligner.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/store_data_aligner_pkg.sv
// store_data_aligner_pkg: shared state codes, lane masks and width helpers for the store path
package store_data_aligner_pkg;
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BEAT1 = 1'b1;
  localparam logic [3:0] MASK_NONE = 4'b0000;
  localparam logic [3:0] MASK_B    = 4'b0001;
  localparam logic [3:0] MASK_H    = 4'b0011;
  localparam logic [3:0] MASK_W    = 4'b1111;
  typedef struct packed {
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } beat_t;
  function automatic logic [3:0] lane_mask(input logic b, input logic h, input logic w);
    return b ? MASK_B : h ? MASK_H : w ? MASK_W : MASK_NONE;
  endfunction
  function automatic logic [31:0] mask_data(input logic [3:0] m, input logic [31:0] d);
    return d & {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction
endpackage

// File: rtl/store_data_aligner_lane_shifter.sv
// store_lane_shifter: shifts lane mask and masked data into a two-word window by byte offset
module store_lane_shifter (
  input  logic [3:0]  m,
  input  logic [31:0] md,
  input  logic [1:0]  off,
  output logic [7:0]  e,
  output logic [63:0] w
);
  assign e = {4'b0, m} << off;
  assign w = {32'b0, md} << {off, 3'b000};
endmodule

// File: rtl/store_data_aligner.sv
// store_data_aligner: turns sb/sh/sw requests into lane-aligned word writes, splitting misaligned ones
module store_data_aligner
  import store_data_aligner_pkg::*;
#(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        STORE_clk,
  input  logic        STORE_rst_n,
  input  logic        STORE_ce,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic        byte_M,
  input  logic        half_word_M,
  input  logic        full_word_M,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        stall_o,
  output logic        misalign_err
);
  logic [3:0]  m;
  logic [31:0] md;
  logic [7:0]  e;
  logic [63:0] w;
  logic [0:0]  state_q, state_d;
  beat_t       out_q, out_d, hold_q, hold_d;
  logic        we_q, we_d, err_q, err_d;
  logic        accept, split;
  assign m = lane_mask(byte_M, half_word_M, full_word_M);
  assign md = mask_data(m, req_data);
  store_lane_shifter u_shift (.m(m), .md(md), .off(req_addr[1:0]), .e(e), .w(w));
  assign req_ready = state_q == ST_IDLE;
  assign stall_o = state_q == ST_BEAT1;
  // a request with no width bit is still consumed, it just never reaches the RAM
  assign accept = STORE_ce & req_valid & req_ready & (m != MASK_NONE);
  assign split = e[7:4] != 4'b0;
  assign mem_we = we_q;
  assign mem_addr = out_q.addr;
  assign mem_be = out_q.be;
  assign mem_wdata = out_q.data;
  assign misalign_err = err_q;
  // pick the beat to issue this edge: pending second beat first, then a fresh request
  always_comb begin
    state_d = state_q;
    out_d = out_q;
    hold_d = hold_q;
    we_d = 1'b0;
    err_d = 1'b0;
    if (STORE_ce && state_q == ST_BEAT1) begin
      state_d = ST_IDLE;
      out_d = hold_q;
      we_d = 1'b1;
    end else if (accept && split && !ALLOW_MISALIGNED) begin
      err_d = 1'b1;
    end else if (accept) begin
      out_d = beat_t'{addr: req_addr[31:2], be: e[3:0], data: w[31:0]};
      we_d = 1'b1;
      if (split) begin
        state_d = ST_BEAT1;
        hold_d = beat_t'{addr: req_addr[31:2] + 30'd1, be: e[7:4], data: w[63:32]};
      end
    end
  end
  // state and registered RAM interface; reset drops any pending second beat
  always_ff @(posedge STORE_clk) begin
    if (!STORE_rst_n) begin
      state_q <= ST_IDLE;
      out_q <= '0;
      hold_q <= '0;
      we_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q <= out_d;
      hold_q <= hold_d;
      we_q <= we_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_store_data_aligner.sv
// tb_store_data_aligner: directed checks of both misalign policies against a byte-level model
module tb_store_data_aligner;
  typedef struct packed {
    logic [29:0] a;
    logic [3:0]  be;
    logic [31:0] d;
  } bt_t;
  logic clk = 1'b0;
  logic rst_n, ce, req_valid, b, h, w;
  logic [31:0] addr, data;
  logic rdy0, we0, stall0, err0, rdy1, we1, stall1, err1;
  logic [29:0] maddr0, maddr1;
  logic [31:0] wd0, wd1;
  logic [3:0] be0, be1;
  int total = 0;
  int bad = 0;
  logic s_rst, s_ce, s_v, s_b, s_h, s_w;
  logic [31:0] s_a, s_d;
  bt_t e_b[2];
  bt_t p_b[2];
  bit p_v[2];
  bit e_we[2];
  bit e_err[2];
  always #5 clk = ~clk;
  store_data_aligner #(.ALLOW_MISALIGNED(1'b0)) dut0 (
    .STORE_clk(clk), .STORE_rst_n(rst_n), .STORE_ce(ce), .req_valid(req_valid), .req_ready(rdy0),
    .req_addr(addr), .req_data(data), .byte_M(b), .half_word_M(h), .full_word_M(w),
    .mem_we(we0), .mem_addr(maddr0), .mem_wdata(wd0), .mem_be(be0), .stall_o(stall0), .misalign_err(err0));
  store_data_aligner #(.ALLOW_MISALIGNED(1'b1)) dut1 (
    .STORE_clk(clk), .STORE_rst_n(rst_n), .STORE_ce(ce), .req_valid(req_valid), .req_ready(rdy1),
    .req_addr(addr), .req_data(data), .byte_M(b), .half_word_M(h), .full_word_M(w),
    .mem_we(we1), .mem_addr(maddr1), .mem_wdata(wd1), .mem_be(be1), .stall_o(stall1), .misalign_err(err1));
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endtask
  // place each stored byte at its own byte address, then group bytes by word
  function automatic int split_bytes(input logic [31:0] a, input logic [31:0] d, input int n,
                                     output bt_t b0, output bt_t b1);
    logic [31:0] ba;
    int c;
    c = 1;
    b0 = '0;
    b1 = '0;
    b0.a = a[31:2];
    b1.a = a[31:2] + 30'd1;
    for (int i = 0; i < n; i++) begin
      ba = a + 32'(i);
      if (ba[31:2] == b0.a) begin
        b0.be[ba[1:0]] = 1'b1;
        b0.d[8*ba[1:0] +: 8] = d[8*i +: 8];
      end else begin
        b1.be[ba[1:0]] = 1'b1;
        b1.d[8*ba[1:0] +: 8] = d[8*i +: 8];
        c = 2;
      end
    end
    return c;
  endfunction
  task automatic model_step();
    int n, c;
    bt_t b0, b1;
    for (int k = 0; k < 2; k++) begin
      e_we[k] = 1'b0;
      e_err[k] = 1'b0;
      if (!s_rst) begin
        e_b[k] = '0;
        p_v[k] = 1'b0;
      end else if (s_ce) begin
        if (p_v[k]) begin
          e_b[k] = p_b[k];
          e_we[k] = 1'b1;
          p_v[k] = 1'b0;
        end else if (s_v) begin
          n = s_b ? 1 : s_h ? 2 : s_w ? 4 : 0;
          if (n > 0) begin
            c = split_bytes(s_a, s_d, n, b0, b1);
            if (c == 1) begin
              e_b[k] = b0;
              e_we[k] = 1'b1;
            end else if (k == 1) begin
              e_b[k] = b0;
              e_we[k] = 1'b1;
              p_b[k] = b1;
              p_v[k] = 1'b1;
            end else begin
              e_err[k] = 1'b1;
            end
          end
        end
      end
    end
  endtask
  initial begin
    forever begin
      @(posedge clk);
      s_rst = rst_n; s_ce = ce; s_v = req_valid; s_b = b; s_h = h; s_w = w; s_a = addr; s_d = data;
      @(negedge clk);
      model_step();
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("m%0d_we", k), k ? we1 : we0, e_we[k]);
        chk($sformatf("m%0d_err", k), k ? err1 : err0, e_err[k]);
        chk($sformatf("m%0d_ready", k), k ? rdy1 : rdy0, !p_v[k]);
        chk($sformatf("m%0d_stall", k), k ? stall1 : stall0, p_v[k]);
        chk($sformatf("m%0d_addr", k), k ? maddr1 : maddr0, e_b[k].a);
        chk($sformatf("m%0d_be", k), k ? be1 : be0, e_b[k].be);
        chk($sformatf("m%0d_wdata", k), k ? wd1 : wd0, e_b[k].d);
      end
    end
  end
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask
  task automatic req(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    {b, h, w} = f;
    addr = a;
    data = d;
    req_valid = 1'b1;
    cyc();
    req_valid = 1'b0;
    {b, h, w} = 3'b000;
  endtask
  initial begin
    rst_n = 1'b0; ce = 1'b1; req_valid = 1'b0; {b, h, w} = 3'b000; addr = '0; data = '0;
    cyc(); cyc();
    chk("rst_we", we1, 0); chk("rst_addr", maddr1, 0); chk("rst_err", err0, 0); chk("rst_ready", rdy1, 1);
    rst_n = 1'b1;
    cyc();
    req(3'b001, 32'h100, 32'hDEADBEEF);
    chk("sw_we", we1, 1); chk("sw_addr", maddr1, 30'h40); chk("sw_be", be1, 4'hF);
    chk("sw_wdata", wd1, 32'hDEADBEEF); chk("sw_stall", stall1, 0);
    cyc();
    chk("sw_one_beat", we1, 0); chk("sw_stall2", stall1, 0);
    req(3'b100, 32'h103, 32'h000000A5);
    chk("sb_be", be1, 4'b1000); chk("sb_wdata", wd1, 32'hA5000000);
    cyc();
    chk("sb_one_beat", we1, 0);
    req(3'b010, 32'h202, 32'h00001234);
    chk("sh_be", be1, 4'b1100); chk("sh_wdata", wd1, 32'h12340000);
    cyc();
    req(3'b001, 32'h105, 32'h11223344);
    chk("mis_b0_addr", maddr1, 30'h41); chk("mis_b0_be", be1, 4'b1110); chk("mis_b0_wdata", wd1, 32'h22334400);
    chk("mis_stall", stall1, 1); chk("mis_ready", rdy1, 0); chk("mis_err0", err0, 1); chk("mis_we0", we0, 0);
    cyc();
    chk("mis_b1_we", we1, 1); chk("mis_b1_addr", maddr1, 30'h42); chk("mis_b1_be", be1, 4'b0001);
    chk("mis_b1_wdata", wd1, 32'h00000011); chk("mis_b1_stall", stall1, 0); chk("mis_err0_pulse", err0, 0);
    cyc();
    req(3'b010, 32'h007, 32'h0000ABCD);
    chk("drop_we0", we0, 0); chk("drop_err0", err0, 1);
    cyc();
    chk("drop_err0_end", err0, 0);
    cyc();
    req(3'b001, 32'hFFFFFFFE, 32'hAABBCCDD);
    chk("wrap_b0_addr", maddr1, 30'h3FFFFFFF); chk("wrap_b0_be", be1, 4'b1100); chk("wrap_b0_wdata", wd1, 32'hCCDD0000);
    cyc();
    chk("wrap_b1_addr", maddr1, 30'h0); chk("wrap_b1_be", be1, 4'b0011); chk("wrap_b1_wdata", wd1, 32'h0000AABB);
    cyc();
    req_valid = 1'b1; w = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr = 32'h300 + 32'(4 * i);
      data = 32'h0F0F0000 + 32'(i);
      cyc();
      chk("b2b_we", we1, 1); chk("b2b_addr", maddr1, 30'hC0 + 30'(i));
    end
    req_valid = 1'b0; w = 1'b0;
    cyc();
    chk("b2b_idle", we1, 0);
    req(3'b000, 32'h10, 32'hFFFF);
    chk("nop_we", we1, 0); chk("nop_err", err0, 0);
    req(3'b111, 32'h602, 32'h12345678);
    chk("prio_addr", maddr1, 30'h180); chk("prio_be", be1, 4'b0100); chk("prio_wdata", wd1, 32'h00780000);
    cyc();
    req(3'b001, 32'h401, 32'hCAFEF00D);
    chk("ce_b0_wdata", wd1, 32'hFEF00D00);
    ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("ce_hold_we", we1, 0); chk("ce_hold_stall", stall1, 1);
    end
    ce = 1'b1;
    cyc();
    chk("ce_b1_we", we1, 1); chk("ce_b1_addr", maddr1, 30'h101); chk("ce_b1_be", be1, 4'b0001); chk("ce_b1_wdata", wd1, 32'hCA);
    cyc();
    chk("ce_b1_once", we1, 0); chk("ce_b1_stall", stall1, 0);
    req(3'b010, 32'h503, 32'h0000BEEF);
    chk("rb_b0_addr", maddr1, 30'h140); chk("rb_b0_be", be1, 4'b1000); chk("rb_b0_wdata", wd1, 32'hEF000000);
    rst_n = 1'b0;
    cyc();
    chk("rb_we", we1, 0); chk("rb_addr", maddr1, 0); chk("rb_be", be1, 0); chk("rb_wdata", wd1, 0); chk("rb_ready", rdy1, 1);
    rst_n = 1'b1;
    cyc();
    chk("rb_no_b1", we1, 0);
    req_valid = 1'b1; w = 1'b1; addr = 32'h702; data = 32'h01020304;
    cyc(); cyc();
    chk("held_b1_addr", maddr1, 30'h1C1); chk("held_b1_we", we1, 1);
    req_valid = 1'b0; w = 1'b0;
    cyc();
    chk("held_no_reaccept", we1, 0);
    for (int off = 0; off < 4; off++) begin
      for (int f = 0; f < 3; f++) begin
        req(3'b001 << f, 32'h800 + 32'(off), $urandom);
        cyc(); cyc();
      end
    end
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
